// File: rtl/bram_ring_reader.sv
// bram_ring_reader: drains committed words from the BRAM sample ring onto a
// valid/ready stream, following the packer's published boundary address.
// Optional fill-level export is compiled in when BRAM_RING_READER_FILL_LEVEL_EN
// is defined; otherwise fill_words is tied to zero.
module bram_ring_reader #(
   parameter int unsigned BRAM_DEPTH_WORDS  = 16384,
   parameter int unsigned BRAM_READ_LATENCY = 1,
   parameter int unsigned OUT_FIFO_DEPTH    = 4,
   localparam int unsigned AW = $clog2(BRAM_DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          enable,
   input  logic          flush,
   input  logic [AW-1:0] boundary_addr,
   output logic [AW+1:0] bram_addr,
   output logic          bram_en,
   input  logic [31:0]   bram_dout,
   output logic          bram_clk,
   output logic          bram_rst,
   output logic [31:0]   m_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic          m_last,
   output logic [AW-1:0] read_addr,
   output logic [AW:0]   fill_words
);

   // Stage 0 of the tracking pipe is the registered read strobe; the last
   // stage lines up with valid bram_dout.
   localparam int unsigned SL = BRAM_READ_LATENCY + 1;
   localparam int unsigned FW = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(OUT_FIFO_DEPTH + SL + 1);

   logic [AW-1:0]             bnd_q, bnd_d;
   logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
   logic                      bram_en_q, bram_en_d;
   logic [AW+1:0]             bram_addr_q, bram_addr_d;
   logic [SL-1:0]             vld_sr_q, vld_sr_d;
   logic [SL-1:0]             tag_sr_q, tag_sr_d;
   logic [31:0]               fifo_data_q [OUT_FIFO_DEPTH];
   logic [31:0]               fifo_data_d [OUT_FIFO_DEPTH];
   logic [OUT_FIFO_DEPTH-1:0] fifo_last_q, fifo_last_d;
   logic [FW-1:0]             wr_idx_q, wr_idx_d;
   logic [FW-1:0]             rd_idx_q, rd_idx_d;
   logic [CW-1:0]             count_q, count_d;
   logic                      m_valid_q, m_valid_d;
   logic                      m_last_q, m_last_d;
   logic [31:0]               m_data_q, m_data_d;
   logic [AW-1:0]             read_addr_q, read_addr_d;
   logic [CW-1:0]             inflight;
   logic                      issue, push, pop;

   function automatic logic [FW-1:0] idx_next(input logic [FW-1:0] i);
      return (i == FW'(OUT_FIFO_DEPTH - 1)) ? '0 : i + FW'(1);
   endfunction

   // Next-state: read issue with credit check, landing pipe, output FIFO, flush.
   always_comb begin
      bnd_d       = boundary_addr;
      rd_ptr_d    = rd_ptr_q;
      bram_addr_d = bram_addr_q;
      fifo_data_d = fifo_data_q;
      fifo_last_d = fifo_last_q;
      wr_idx_d    = wr_idx_q;
      rd_idx_d    = rd_idx_q;
      read_addr_d = read_addr_q;
      inflight    = '0;

      for (int i = 0; i < SL; i++) begin
         inflight = inflight + CW'(vld_sr_q[i]);
      end

      issue = enable && (rd_ptr_q != bnd_q) &&
              ((count_q + inflight) < CW'(OUT_FIFO_DEPTH)) && !flush;
      push  = vld_sr_q[SL-1];
      pop   = m_valid_q && m_ready;

      bram_en_d = issue;
      vld_sr_d  = {vld_sr_q[SL-2:0], issue};
      tag_sr_d  = {tag_sr_q[SL-2:0], ((rd_ptr_q + AW'(1)) == bnd_q)};

      if (issue) begin
         rd_ptr_d    = rd_ptr_q + AW'(1);
         bram_addr_d = {rd_ptr_q, 2'b00};
      end

      if (push) begin
         fifo_data_d[wr_idx_q] = bram_dout;
         fifo_last_d[wr_idx_q] = tag_sr_q[SL-1];
         wr_idx_d              = idx_next(wr_idx_q);
      end

      if (pop) begin
         rd_idx_d    = idx_next(rd_idx_q);
         read_addr_d = read_addr_q + AW'(1);
      end

      count_d = count_q + CW'(push) - CW'(pop);

      // Flush wins over any issue or handshake in the same cycle.
      if (flush) begin
         vld_sr_d    = '0;
         count_d     = '0;
         wr_idx_d    = '0;
         rd_idx_d    = '0;
         rd_ptr_d    = bnd_q;
         read_addr_d = bnd_q;
      end

      // Stream outputs are registered views of the FIFO head after this edge.
      m_valid_d = (count_d != '0);
      m_data_d  = fifo_data_d[rd_idx_d];
      m_last_d  = fifo_last_d[rd_idx_d];
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         bnd_q       <= '0;
         rd_ptr_q    <= '0;
         bram_en_q   <= 1'b0;
         bram_addr_q <= '0;
         vld_sr_q    <= '0;
         tag_sr_q    <= '0;
         for (int i = 0; i < OUT_FIFO_DEPTH; i++) begin
            fifo_data_q[i] <= '0;
         end
         fifo_last_q <= '0;
         wr_idx_q    <= '0;
         rd_idx_q    <= '0;
         count_q     <= '0;
         m_valid_q   <= 1'b0;
         m_last_q    <= 1'b0;
         m_data_q    <= '0;
         read_addr_q <= '0;
      end else begin
         bnd_q       <= bnd_d;
         rd_ptr_q    <= rd_ptr_d;
         bram_en_q   <= bram_en_d;
         bram_addr_q <= bram_addr_d;
         vld_sr_q    <= vld_sr_d;
         tag_sr_q    <= tag_sr_d;
         fifo_data_q <= fifo_data_d;
         fifo_last_q <= fifo_last_d;
         wr_idx_q    <= wr_idx_d;
         rd_idx_q    <= rd_idx_d;
         count_q     <= count_d;
         m_valid_q   <= m_valid_d;
         m_last_q    <= m_last_d;
         m_data_q    <= m_data_d;
         read_addr_q <= read_addr_d;
      end
   end

`ifdef BRAM_RING_READER_FILL_LEVEL_EN
   logic [AW:0] fill_q, fill_d;

   // Committed-but-unissued words, taken from the post-edge pointers.
   always_comb begin
      fill_d = {1'b0, bnd_d - rd_ptr_d};
   end

   // Fill-level register.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         fill_q <= '0;
      end else begin
         fill_q <= fill_d;
      end
   end

   assign fill_words = fill_q;
`else
   assign fill_words = '0;
`endif

   assign bram_clk  = clk;
   assign bram_rst  = ~rstn;
   assign bram_en   = bram_en_q;
   assign bram_addr = bram_addr_q;
   assign m_valid   = m_valid_q;
   assign m_data    = m_data_q;
   assign m_last    = m_last_q;
   assign read_addr = read_addr_q;

endmodule

// File: tb/tb_bram_ring_reader.sv
// Testbench for bram_ring_reader: random ready, scoreboard of committed words.
module tb_bram_ring_reader;

   typedef struct packed {
      logic [13:0] a;
      logic [31:0] d;
      logic        l;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstn, enable, flush, m_ready;
   logic [13:0] boundary_addr;
   logic [15:0] bram_addr;
   logic        bram_en, bram_clk, bram_rst;
   logic [31:0] bram_dout = '0;
   logic [31:0] m_data;
   logic        m_valid, m_last;
   logic [13:0] read_addr;
   logic [14:0] fill_words;

   int          errors = 0;
   int          checks = 0;
   int          hs_cnt = 0;
   int          iss_cnt = 0;
   int          mode = 0;
   exp_t        exp_q[$];
   logic [13:0] bnd = '0;
   logic [13:0] ptr_cmt = '0;
   logic [13:0] iss_ptr = '0;
   logic        p_hold = 1'b0;
   logic        p_last = 1'b0;
   logic [31:0] p_data = '0;

   always #5 clk = ~clk;

   bram_ring_reader dut (
      .clk(clk), .rstn(rstn), .enable(enable), .flush(flush),
      .boundary_addr(boundary_addr), .bram_addr(bram_addr), .bram_en(bram_en),
      .bram_dout(bram_dout), .bram_clk(bram_clk), .bram_rst(bram_rst),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
      .read_addr(read_addr), .fill_words(fill_words)
   );

   // Ring contents: a bijective hash of the word address.
   function automatic logic [31:0] wf(input logic [13:0] a);
      return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // One-cycle-latency BRAM model.
   always @(posedge clk) begin
      if (bram_en) bram_dout <= wf(bram_addr[15:2]);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance the committed boundary; every newly committed word is expected in order.
   task automatic set_bnd(input logic [13:0] nb);
      exp_t e;
      while (ptr_cmt != nb) begin
         e.a = ptr_cmt;
         e.d = wf(ptr_cmt);
         e.l = ((ptr_cmt + 14'd1) == nb);
         exp_q.push_back(e);
         ptr_cmt = ptr_cmt + 14'd1;
      end
      bnd = nb;
      boundary_addr = nb;
   endtask

   task automatic wait_drain(input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         if (exp_q.size() == 0) break;
         tick();
      end
      if (exp_q.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
      end
      repeat (4) tick();
   endtask

   task automatic idle_checks(input string tag);
      @(negedge clk);
      chk({tag, "_read_addr"}, 64'(read_addr), 64'(ptr_cmt));
      chk({tag, "_valid_idle"}, 64'(m_valid), 64'd0);
`ifdef BRAM_RING_READER_FILL_LEVEL_EN
      chk({tag, "_fill"}, 64'(fill_words), 64'(15'(bnd - iss_ptr)));
`else
      chk({tag, "_fill"}, 64'(fill_words), 64'd0);
`endif
   endtask

   // Ready generator: forced low, forced high, or random.
   initial begin
      m_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: issue addresses, hold stability, and scoreboard on handshakes.
   always @(negedge clk) begin
      exp_t e;
      if (!rstn) begin
         exp_q.delete();
         iss_ptr = '0;
         p_hold  = 1'b0;
      end else begin
         if (bram_en) begin
            iss_cnt++;
            chk("issue_addr", 64'(bram_addr), 64'({iss_ptr, 2'b00}));
            iss_ptr = iss_ptr + 14'd1;
         end
         if (p_hold) begin
            chk("hold_stable", 64'({m_valid, m_last, m_data}), 64'({1'b1, p_last, p_data}));
         end
         if (flush) begin
            exp_q.delete();
            iss_ptr = bnd;
         end else if (m_valid && m_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
               errors++;
               checks++;
               $display("FAIL unexpected_word: got data %0h at read_addr %0h, required no word",
                        m_data, read_addr);
            end else begin
               e = exp_q.pop_front();
               chk("word_data", 64'(m_data), 64'(e.d));
               chk("word_last", 64'(m_last), 64'(e.l));
               chk("word_read_addr", 64'(read_addr), 64'(e.a));
            end
         end
         p_hold = m_valid && !m_ready && !flush;
         p_data = m_data;
         p_last = m_last;
      end
   end

   initial begin
      #900000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      int lat, hs0, is0, len, i;
      rstn = 1'b0; enable = 1'b0; flush = 1'b0; boundary_addr = '0;
      repeat (3) tick();
      rstn = 1'b1;
      tick();
      @(negedge clk);
      chk("rst_bram_en", 64'(bram_en), 64'd0);
      chk("rst_bram_addr", 64'(bram_addr), 64'd0);
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_m_data", 64'(m_data), 64'd0);
      chk("rst_m_last", 64'(m_last), 64'd0);
      chk("rst_read_addr", 64'(read_addr), 64'd0);
      chk("rst_fill", 64'(fill_words), 64'd0);
      chk("rst_bram_rst", 64'(bram_rst), 64'd0);

      // Boundary 0 -> 4 at full ready: latency and back-to-back words.
      enable = 1'b1; mode = 1;
      tick();
      hs0 = hs_cnt;
      set_bnd(14'd4);
      @(posedge clk);
      lat = -1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (m_valid) begin
            lat = k;
            break;
         end
      end
      chk("first_valid_latency", 64'(lat), 64'd3);
      repeat (4) @(posedge clk);
      #1;
      chk("burst4_consecutive", 64'(hs_cnt - hs0), 64'd4);
      wait_drain(100);
      idle_checks("burst4");

      // Stalled stream with 8 committed words.
      mode = 0;
      is0 = iss_cnt; hs0 = hs_cnt;
      set_bnd(bnd + 14'd8);
      repeat (20) tick();
      chk("stall_issue_le4", 64'((iss_cnt - is0) <= 4), 64'd1);
      chk("stall_valid_held", 64'(m_valid), 64'd1);
      mode = 1;
      wait_drain(200);
      chk("stall_release_count", 64'(hs_cnt - hs0), 64'd8);
      idle_checks("stall");

      // Enable low after exactly two issue cycles, then resume.
      enable = 1'b0;
      hs0 = hs_cnt; is0 = iss_cnt;
      set_bnd(bnd + 14'd10);
      repeat (3) tick();
      enable = 1'b1;
      repeat (2) tick();
      enable = 1'b0;
      repeat (10) tick();
      chk("enable_issues", 64'(iss_cnt - is0), 64'd2);
      chk("enable_words", 64'(hs_cnt - hs0), 64'd2);
      enable = 1'b1;
      wait_drain(200);
      idle_checks("enable");

      // Flush while words are buffered and in flight.
      mode = 0;
      set_bnd(bnd + 14'd8);
      repeat ($urandom_range(3, 6)) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      @(negedge clk);
      chk("flush_valid_drop", 64'(m_valid), 64'd0);
      chk("flush_read_addr", 64'(read_addr), 64'(bnd));
      tick();
      hs0 = hs_cnt;
      mode = 1;
      repeat (12) tick();
      chk("flush_no_stale", 64'(hs_cnt - hs0), 64'd0);
      set_bnd(bnd + 14'd5);
      wait_drain(200);
      idle_checks("flush");

      // Wrap: reposition to 16382 through flush, then commit up to 2.
      enable = 1'b0;
      bnd = 14'd16382; boundary_addr = 14'd16382;
      repeat (3) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      ptr_cmt = 14'd16382;
      @(negedge clk);
      chk("wrap_read_addr", 64'(read_addr), 64'd16382);
      tick();
      enable = 1'b1; mode = 2;
      set_bnd(14'd2);
      wait_drain(200);
      idle_checks("wrap");

      // Fill level with 100 committed, ~30 consumed, then stalled.
      mode = 1;
      hs0 = hs_cnt;
      set_bnd(bnd + 14'd100);
      for (i = 0; i < 500; i++) begin
         if ((hs_cnt - hs0) >= 30) break;
         tick();
      end
      mode = 0;
      repeat (10) tick();
      @(negedge clk);
`ifdef BRAM_RING_READER_FILL_LEVEL_EN
      chk("fill_exact", 64'(fill_words), 64'(15'(bnd - iss_ptr)));
      chk("fill_le70", 64'(fill_words <= 15'd70), 64'd1);
`else
      chk("fill_tied_zero", 64'(fill_words), 64'd0);
`endif
      tick();
      mode = 1;
      wait_drain(500);
      idle_checks("fill");

      // Random packet lengths under random ready.
      for (int p = 0; p < 25; p++) begin
         mode = 2;
         len = $urandom_range(1, 40);
         set_bnd(bnd + 14'(len));
         wait_drain(2000);
         idle_checks("random");
      end

      // Reset mid-stream discards everything.
      mode = 0;
      set_bnd(bnd + 14'd6);
      repeat (5) tick();
      rstn = 1'b0;
      boundary_addr = '0; bnd = '0;
      repeat (2) tick();
      @(negedge clk);
      chk("midrst_valid", 64'(m_valid), 64'd0);
      chk("midrst_bram_en", 64'(bram_en), 64'd0);
      chk("midrst_read_addr", 64'(read_addr), 64'd0);
      chk("midrst_bram_rst", 64'(bram_rst), 64'd1);
      tick();
      rstn = 1'b1;
      ptr_cmt = '0;
      exp_q.delete();
      hs0 = hs_cnt;
      mode = 1;
      repeat (10) tick();
      chk("midrst_no_words", 64'(hs_cnt - hs0), 64'd0);
      idle_checks("midrst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
